// File: rtl/dm_bus_pkg.sv
// Shared types and defaults for the data-memory bus controller.
// Holds the controller state encoding, the default timeout/error data, and the read byte-enable constant.
package dm_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          DEF_TIMEOUT  = 255;
    localparam int          DEF_TO_W     = 8;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  BE_READ      = 4'hF;

endpackage

// File: rtl/dm_timeout_cnt.sv
// Saturating wait-state counter; flags expiry once TIMEOUT-1 REQ cycles have elapsed.
// Counts only while enabled and holds at all-ones instead of wrapping.
module dm_timeout_cnt
    import dm_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/dm_bus_ctrl.sv
// Bridges the single-cycle MEM-stage DM port onto a req/ack bus with wait states and timeout.
// The pipeline is stalled from request until the DONE cycle; only cpu_stall is combinational.
module dm_bus_ctrl
    import dm_bus_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter int                TO_W     = DEF_TO_W,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mem_w,
    input  logic              cpu_mem_r,
    input  logic [3:0]        cpu_wea,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);

    state_t state, state_next;
    logic   launch, done_ok, done_to;
    logic   cnt_clr, cnt_en, expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_mem_w || cpu_mem_r) begin
                    launch     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    done_ok    = 1'b1;
                    state_next = S_DONE;
                end else if (expired) begin
                    done_to    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign cpu_stall = ((state == S_IDLE) && (cpu_mem_w || cpu_mem_r)) || (state == S_REQ);
    assign cnt_en    = (state == S_REQ);
    assign cnt_clr   = (state != S_REQ) || done_ok || done_to;

    dm_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            cpu_rdata <= '0;
            err_addr  <= '0;
        end else begin
            bus_req <= (state_next == S_REQ);
            bus_err <= done_to;
            if (launch) begin
                bus_addr  <= cpu_addr;
                bus_wdata <= cpu_wdata;
                bus_we    <= cpu_mem_w;
                bus_be    <= cpu_mem_w ? cpu_wea : BE_READ;
            end
            if (done_ok && !bus_we) begin
                cpu_rdata <= bus_rdata;
            end
            // A timed-out load still completes, returning the poison word.
            if (done_to) begin
                err_addr <= bus_addr;
                if (!bus_we) begin
                    cpu_rdata <= ERR_DATA;
                end
            end
        end
    end

endmodule
